// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// grant identifiers and the line-offset width helper.
package mem_bus_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BURST_I = 2'd1,
    BURST_D = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  // Grant identifiers; also the bit positions in the request vector
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // Number of byte-address bits covered by one cache line
  function automatic int offset_bits(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  // Line offset width for the default 4-word line
  localparam int OFFSET_BITS = offset_bits(4);

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the side that did not win last time. Purely combinational.
module mem_rr_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  // Pick the winner from the request vector and the previous owner
  always_comb begin
    valid = |req;
    grant = GNT_I;
    if (req[GNT_I] && req[GNT_D]) begin
      grant = ~last_grant;
    end else if (req[GNT_D]) begin
      grant = GNT_D;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter between the I-cache refill engine and the D-cache miss
// engine. One requester owns the bus for a whole line burst; beats are
// sequenced here and read data / write-beat handshakes go back to the owner.
// Optional per-beat watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_wnext,
  output logic [31:0]       d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  localparam int OFF_W  = offset_bits(LINE_WORDS);
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  // Reject geometries the address slicing cannot represent
  if (LINE_WORDS < 2 || LINE_WORDS > 16 || (LINE_WORDS & (LINE_WORDS - 1)) != 0 || TIMEOUT < 1)
  begin : g_bad_params
    $error("mem_bus_arbiter: unsupported LINE_WORDS or TIMEOUT");
  end

  arb_state_e                state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [ADDR_W-OFF_W-1:0]   base_q, base_d;
  logic                      we_q, we_d;
  logic                      last_grant_q, last_grant_d;
  logic [31:0]               i_hold_q, i_hold_d;
  logic [31:0]               d_hold_q, d_hold_d;
  logic                      pick_grant;
  logic                      pick_valid;
  logic                      in_burst_i;
  logic                      in_burst_d;
  logic                      unused_addr_bits;

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // Only the line base is latched; the in-line offset comes from the beat counter
  assign unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

  mem_rr_pick u_pick (
    .req        ({d_req, i_req}),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  assign in_burst_i = (state_q == BURST_I);
  assign in_burst_d = (state_q == BURST_D);

  assign mem_req   = in_burst_i | in_burst_d;
  assign mem_we    = in_burst_d & we_q;
  assign mem_addr  = {base_q, beat_q, 2'b00};
  assign mem_wdata = mem_we ? d_wdata : 32'h0;
  assign i_rvalid  = in_burst_i & mem_ack;
  assign d_rvalid  = in_burst_d & ~we_q & mem_ack;
  assign d_wnext   = in_burst_d & we_q & mem_ack;
  assign i_rdata   = i_rvalid ? mem_rdata : i_hold_q;
  assign d_rdata   = d_rvalid ? mem_rdata : d_hold_q;
  assign i_done    = (state_q == DONE) & (last_grant_q == GNT_I);
  assign d_done    = (state_q == DONE) & (last_grant_q == GNT_D);

`ifdef ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state logic: grant in IDLE, step beats on ack, one-cycle DONE
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    base_d       = base_q;
    we_d         = we_q;
    last_grant_d = last_grant_q;
    i_hold_d     = i_rvalid ? mem_rdata : i_hold_q;
    d_hold_d     = d_rvalid ? mem_rdata : d_hold_q;
`ifdef ARB_TIMEOUT_EN
    wd_d  = '0;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          last_grant_d = pick_grant;
          beat_d       = '0;
          if (pick_grant == GNT_D) begin
            base_d  = d_addr[ADDR_W-1:OFF_W];
            we_d    = d_we;
            state_d = BURST_D;
          end else begin
            base_d  = i_addr[ADDR_W-1:OFF_W];
            we_d    = 1'b0;
            state_d = BURST_I;
          end
        end
      end
      BURST_I, BURST_D: begin
        if (mem_ack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (wd_q >= WD_W'(TIMEOUT)) begin
          // Memory stopped answering: close the burst without more data
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any burst and hands the first tie to D
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      base_q       <= '0;
      we_q         <= 1'b0;
      last_grant_q <= GNT_I;
      i_hold_q     <= '0;
      d_hold_q     <= '0;
`ifdef ARB_TIMEOUT_EN
      wd_q         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      we_q         <= we_d;
      last_grant_q <= last_grant_d;
      i_hold_q     <= i_hold_d;
      d_hold_q     <= d_hold_d;
`ifdef ARB_TIMEOUT_EN
      wd_q         <= wd_d;
      err_q        <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand-made
// corner sequences and randomized episodes against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int LW = 4;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [31:0]   i_rdata;
  logic          i_rvalid, i_done;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [31:0]   d_wdata = '0;
  logic          d_wnext;
  logic [31:0]   d_rdata;
  logic          d_rvalid, d_done;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wnext(d_wnext),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  // One expected line burst
  typedef struct packed {
    logic                 owner;   // 0 = I, 1 = D
    logic [31:0]          base;
    logic                 we;
    logic [LW-1:0][31:0]  wd;
  } burst_t;

  // Directed vector: requests, addresses and the hand-derived grant order
  typedef struct {
    bit          wi;
    bit          wd;
    logic [31:0] ia;
    logic [31:0] da;
    bit          dwe;
    int          gap;
    int          exp_n;
    logic [31:0] exp_first;
    logic [31:0] exp_second;
  } vec_t;

  burst_t              exp_q[$];
  logic [31:0]         starts[$];
  logic [LW-1:0][31:0] wr_words;
  logic [LW-1:0][31:0] aa_words;
  vec_t                tbl[5];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int beat_idx = 0;
  int wait_cnt = 0;
  int gap_now = 0;
  int gap_mode = 0;
  int d_wptr = 0;
  int exp_req_cycle = -1;
  int rise_cyc = 0;
  bit ack_enable = 1'b1;
  bit expect_timeout = 1'b0;
  bit done_due = 1'b0;
  bit in_flight = 1'b0;
  bit prev_mem_req = 1'b0;
  bit model_last = 1'b0;
  logic [31:0] exp_i_rd = '0;
  logic [31:0] exp_d_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & ~32'(LW * 4 - 1);
  endfunction

  function automatic int pick_gap();
    if (gap_mode < 0) return int'($urandom_range(3, 0));
    return gap_mode;
  endfunction

  function automatic burst_t mk(input logic owner, input logic [31:0] addr, input logic we,
                                input logic [LW-1:0][31:0] wd);
    burst_t b;
    b.owner = owner;
    b.base  = line_base(addr);
    b.we    = owner & we;
    b.wd    = wd;
    return b;
  endfunction

  // One bus cycle: act as memory and D-side writer, then check everything visible
  task automatic step();
    burst_t     h;
    bit         vi, vd, vw, due;
    logic [1:0] exp_done;
    mem_ack = 1'b0;
    if (mem_req && ack_enable) begin
      if (wait_cnt >= gap_now) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
      end else begin
        wait_cnt++;
      end
    end
    d_wdata = (d_wptr < LW) ? wr_words[d_wptr] : 32'hDEAD_BEEF;
    #1;
    if (mem_req && !prev_mem_req) begin
      chk("burst_start_cycle", 32'(cyc), 32'(exp_req_cycle));
      starts.push_back(mem_addr);
      rise_cyc  = cyc;
      in_flight = 1'b1;
    end
    prev_mem_req = mem_req;

    // Burst completion: due one cycle after the last ack, or after the watchdog span
    due = done_due || (expect_timeout && in_flight && (cyc == rise_cyc + TO + 1));
    exp_done = 2'b00;
    if (due && exp_q.size() > 0) exp_done = exp_q[0].owner ? 2'b01 : 2'b10;
    chk("done_pulse", 32'({i_done, d_done}), 32'(exp_done));

    vi = 1'b0; vd = 1'b0; vw = 1'b0;
    if (mem_ack) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got beat at 0x%0h, want none (cycle %0d)", mem_addr, cyc);
      end else begin
        h = exp_q[0];
        chk("beat_addr", mem_addr, h.base + 32'(4 * beat_idx));
        chk("beat_we", 32'(mem_we), 32'(h.we));
        if (h.we) chk("beat_wdata", mem_wdata, h.wd[beat_idx]);
        vi = ~h.owner;
        vd = h.owner & ~h.we;
        vw = h.owner & h.we;
        beat_idx++;
      end
      wait_cnt = 0;
      gap_now  = pick_gap();
    end
    chk("beat_strobes", 32'({i_rvalid, d_rvalid, d_wnext}), 32'({vi, vd, vw}));
    if (vi) exp_i_rd = mem_rdata;
    if (vd) exp_d_rd = mem_rdata;
    chk("i_rdata", i_rdata, exp_i_rd);
    chk("d_rdata", d_rdata, exp_d_rd);
    if (d_wnext) d_wptr++;

    if (due && exp_q.size() > 0) begin
      h = exp_q[0];
      chk("done_mem_req_low", 32'(mem_req), 32'h0);
      chk("err_at_done", 32'(err), 32'(expect_timeout));
      $display("[TB] burst %s base=0x%08h we=%0d beats=%0d done@%0d", h.owner ? "D" : "I",
               h.base, h.we, beat_idx, cyc);
      if (h.owner) d_req = 1'b0;
      else         i_req = 1'b0;
      model_last = h.owner;
      void'(exp_q.pop_front());
      beat_idx  = 0;
      d_wptr    = 0;
      done_due  = 1'b0;
      in_flight = 1'b0;
      if (exp_q.size() > 0) exp_req_cycle = cyc + 2;
    end else if (exp_q.size() > 0 && beat_idx == LW) begin
      done_due = 1'b1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_empty();
    int n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL episode_budget: got %0d bursts outstanding, want 0 (cycle %0d)", exp_q.size(), cyc);
      exp_q.delete();
    end
  endtask

  // Raise one or both requests together; the model decides the order from round-robin
  task automatic run_episode(input bit wi, input bit wd, input logic [31:0] ia,
                             input logic [31:0] da, input bit dwe, input int gm,
                             input logic [LW-1:0][31:0] words);
    i_addr   = ia;
    d_addr   = da;
    d_we     = dwe;
    wr_words = words;
    gap_mode = gm;
    gap_now  = pick_gap();
    wait_cnt = 0;
    d_wptr   = 0;
    starts.delete();
    if (wi && wd) begin
      if (model_last) begin
        exp_q.push_back(mk(1'b0, ia, 1'b0, words));
        exp_q.push_back(mk(1'b1, da, dwe, words));
      end else begin
        exp_q.push_back(mk(1'b1, da, dwe, words));
        exp_q.push_back(mk(1'b0, ia, 1'b0, words));
      end
    end else if (wd) begin
      exp_q.push_back(mk(1'b1, da, dwe, words));
    end else begin
      exp_q.push_back(mk(1'b0, ia, 1'b0, words));
    end
    i_req = wi;
    d_req = wd;
    exp_req_cycle = cyc + 1;
    run_until_empty();
    step();
    step();
  endtask

  task automatic model_reset();
    exp_q.delete();
    beat_idx     = 0;
    done_due     = 1'b0;
    in_flight    = 1'b0;
    exp_i_rd     = '0;
    exp_d_rd     = '0;
    model_last   = 1'b0;
    prev_mem_req = 1'b0;
    wait_cnt     = 0;
    d_wptr       = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got no finish, want finish (cycle %0d)", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int n;
    logic [LW-1:0][31:0] rw;
    for (int k = 0; k < LW; k++) aa_words[k] = 32'hAA0 + 32'(k);
    wr_words = aa_words;

    tbl[0] = '{1, 1, 32'h0000_1234, 32'h0000_0080, 0, 0, 2, 32'h0000_0080, 32'h0000_1230};
    tbl[1] = '{1, 0, 32'h0000_1234, 32'h0000_0000, 0, 1, 1, 32'h0000_1230, 32'h0};
    tbl[2] = '{0, 1, 32'h0000_0000, 32'h0000_0080, 1, 0, 1, 32'h0000_0080, 32'h0};
    tbl[3] = '{1, 1, 32'h0000_2000, 32'h0000_3040, 1, 2, 2, 32'h0000_2000, 32'h0000_3040};
    tbl[4] = '{1, 1, 32'h0000_7FFC, 32'h0000_1000, 0, 0, 2, 32'h0000_7FF0, 32'h0000_1000};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", 32'({mem_req, mem_we, i_rvalid, d_rvalid, d_wnext, i_done, d_done, err}), 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_rdata", i_rdata | d_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // Directed vector table
    for (int k = 0; k < 5; k++) begin
      run_episode(tbl[k].wi, tbl[k].wd, tbl[k].ia, tbl[k].da, tbl[k].dwe, tbl[k].gap, aa_words);
      chk("vec_burst_count", 32'(starts.size()), 32'(tbl[k].exp_n));
      chk("vec_first_grant", starts[0], tbl[k].exp_first);
      if (tbl[k].exp_n == 2) chk("vec_second_grant", starts[1], tbl[k].exp_second);
    end

    // I drops its request mid-burst while D arrives; address changes are ignored
    gap_mode = 0; gap_now = 0; wait_cnt = 0; d_wptr = 0;
    i_addr = 32'h0000_4000;
    exp_q.push_back(mk(1'b0, 32'h0000_4000, 1'b0, aa_words));
    i_req = 1'b1;
    exp_req_cycle = cyc + 1;
    n = 0;
    while (beat_idx < 2 && n < 50) begin step(); n++; end
    i_req  = 1'b0;
    i_addr = 32'hFFFF_FFF0;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_5008;
    exp_q.push_back(mk(1'b1, 32'h0000_5008, 1'b0, aa_words));
    run_until_empty();
    step();

    // Reset in the middle of a D refill, then restart from beat 0
    gap_mode = 1; gap_now = 1; wait_cnt = 0;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 32'h0000_0200;
    exp_q.push_back(mk(1'b1, 32'h0000_0200, 1'b0, aa_words));
    exp_req_cycle = cyc + 1;
    n = 0;
    while (beat_idx < 2 && n < 50) begin step(); n++; end
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'h0);
    chk("abort_outputs", 32'({mem_we, i_rvalid, d_rvalid, d_wnext, i_done, d_done, err}), 32'h0);
    chk("abort_d_rdata", d_rdata, 32'h0);
    model_reset();
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    gap_now = pick_gap();
    exp_q.push_back(mk(1'b1, 32'h0000_0200, 1'b0, aa_words));
    exp_req_cycle = cyc + 1;
    run_until_empty();
    step();

    // Randomized episodes against the transaction model
    for (int e = 0; e < 25; e++) begin
      bit wi, wd;
      wi = 1'($urandom);
      wd = 1'($urandom);
      if (!wi && !wd) wd = 1'b1;
      for (int k = 0; k < LW; k++) rw[k] = $urandom;
      run_episode(wi, wd, $urandom, $urandom, 1'($urandom), -1, rw);
    end

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: watchdog closes the burst and raises a sticky err
    ack_enable     = 1'b0;
    expect_timeout = 1'b1;
    i_addr = 32'h0000_6000;
    exp_q.push_back(mk(1'b0, 32'h0000_6000, 1'b0, aa_words));
    i_req = 1'b1;
    exp_req_cycle = cyc + 1;
    run_until_empty();
    chk("timeout_span", 32'(cyc - 1 - rise_cyc), 32'(TO + 1));
    step();
    step();
    step();
    chk("err_sticky", 32'(err), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("err_cleared_by_reset", 32'(err), 32'h0);
    model_reset();
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    ack_enable     = 1'b1;
    expect_timeout = 1'b0;
    step();
`else
    chk("err_tied_low", 32'(err), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-ported main-memory bus between the I-cache refill engine and the D-cache miss engine (line refill or dirty-line writeback).
- Grants one requester at a time, locks the bus for a full line burst and sequences per-word beats.
- Routes read data and write-data requests back to the owner and signals burst completion.
- Sits between the cache controllers (which generate ICacheMiss/DCacheMiss stalls) and the memory model.

Parameters:
- LINE_WORDS, 4: words per cache line (power of 2, 2..16); burst length in beats.
- ADDR_W, 32: byte-address width.
- TIMEOUT, 255: maximum cycles waiting for mem_ack on one beat (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  I-side line read request; held high until i_done
- i_addr  in  ADDR_W  I-side line address; low log2(LINE_WORDS)+2 bits ignored
- i_rdata  out  32  I-side beat read data
- i_rvalid  out  1  I-side beat valid (1-cycle pulse per word)
- i_done  out  1  I-side burst complete (1-cycle pulse)
- d_req  in  1  D-side request; held high until d_done
- d_we  in  1  D-side direction: 1 = writeback, 0 = refill
- d_addr  in  ADDR_W  D-side line address; low bits ignored
- d_wdata  in  32  D-side write word for the current beat
- d_wnext  out  1  pulse: current write beat accepted; present the next word on the following cycle
- d_rdata  out  32  D-side beat read data
- d_rvalid  out  1  D-side beat valid pulse
- d_done  out  1  D-side burst complete pulse
- mem_req  out  1  beat request to memory
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  word-aligned beat address
- mem_wdata  out  32  beat write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  beat complete (1-cycle pulse)
- err  out  1  timeout flag (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- The interface is fixed: one clock, clk; asynchronous active-low reset, rst_n.
- Reset: FSM enters IDLE; beat counter = 0; last_grant = I, so D wins the first tie. All outputs are 0.
- FSM states: IDLE, BURST_I, BURST_D, DONE.
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the side opposite last_grant (round-robin).
  - On grant: latch the line base (address with low bits cleared) and d_we. Update last_grant. Clear the beat counter.
  - Go to BURST_x on the next cycle.
- BURST_x:
  - mem_req = 1.
  - mem_addr = base + 4*beat.
  - mem_we = latched d_we for D, 0 for I.
  - mem_wdata = d_wdata (combinational passthrough).
  - On mem_ack:
    - Read beats: rdata = mem_rdata and rvalid pulses in the same cycle.
    - Write beats: d_wnext pulses in the same cycle.
    - Beat counter increments.
  - On the ack of beat LINE_WORDS-1: go to DONE.
  - mem_req stays high between beats. The earliest next beat is the cycle after an ack.
- DONE:
  - Pulse x_done for one cycle, mem_req = 0, return to IDLE.
  - The next grant is decided in that IDLE cycle, so there is at least 1 idle bus cycle between bursts.
- Request rules:
  - A requester dropping req mid-burst is ignored; the burst completes.
  - A req edge during the other side's burst waits; no starvation, because round-robin guarantees a grant within one burst.
  - i_addr, d_addr and d_we changing after grant are ignored.
- Latency: an uncontended request rising at cycle t gives mem_req at t+1 and done at (last ack)+1.
- rvalid/d_wnext are never asserted to the non-owner. rdata outputs hold their last value when not valid.
- rst_n asserted mid-burst: immediate abort to IDLE, all outputs 0. Requesters restart from scratch.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With it defined:
  - A per-beat watchdog counts cycles with mem_req=1 and no mem_ack.
  - On reaching TIMEOUT: err is set (sticky until reset), the burst aborts to DONE, and the owner gets x_done with no further rvalid.
  - The counter clears on every ack.
- Without it: no counter, err = 0, and the arbiter waits indefinitely.

Decomposition:
- Shared package: state encoding (IDLE/BURST_I/BURST_D/DONE), grant IDs (GNT_I=0, GNT_D=1), and the derived constant OFFSET_BITS = log2(LINE_WORDS)+2.
- One natural sub-module: mem_rr_pick, a 2-way round-robin picker (req vector + last_grant -> grant + valid), purely combinational.
- FSM, beat counter and watchdog stay in the top.

Test Plan:
- Lone I refill: i_req with i_addr=0x0000_1234, memory acks every 2nd cycle -> mem_addr 0x1230, 0x1234, 0x1238, 0x123C; 4 i_rvalid pulses carrying mem_rdata; one i_done; d_* outputs stay 0.
- D writeback: d_we=1, d_addr=0x80, d_wdata stepped on each d_wnext to AA0..AA3 -> mem_we=1 with mem_wdata AA0..AA3 at 0x80..0x8C; 4 d_wnext pulses; d_done.
- Simultaneous i_req and d_req right after reset -> D granted first, then I. Repeat the tie -> I first (round-robin alternates).
- d_req rises during an I burst and i_req is dropped mid-burst -> the I burst still completes all 4 beats with i_done; D is granted in the cycle after DONE.
- rst_n pulled low after beat 2 -> mem_req=0 and FSM in IDLE immediately; after release with d_req high, the burst restarts at beat 0.
- With ARB_TIMEOUT_EN and TIMEOUT=8, memory never acks -> err=1 and i_done pulse 9 cycles after mem_req rises; err remains set until reset.
